// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: one add-3 correction plus
// one left shift per clock, IN_WIDTH shift cycles per conversion.
module bin_to_bcd_seq #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned SIGNED   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 accept, last_shift;

  logic [IN_WIDTH-1:0]  operand_q;
  logic [BCD_W-1:0]     digits_q;
  logic                 ovf_sticky_q;
  logic                 sign_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 bin_neg;
  logic [IN_WIDTH-1:0]  bin_mag;
  logic [BCD_W-1:0]     digits_corr;
  logic [BCD_W-1:0]     digits_shl;
  logic [IN_WIDTH-1:0]  operand_shl;
  logic                 carry_out;

  // Magnitude capture; the most negative input wraps to 2^(IN_WIDTH-1) unsigned.
  assign bin_neg = (SIGNED != 0) && bin[IN_WIDTH-1];
  assign bin_mag = bin_neg ? ((~bin) + IN_WIDTH'(1)) : bin;

  // Per-digit add-3 correction, no carry between digits.
  always_comb begin
    digits_corr = digits_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (digits_q[4*i +: 4] >= 4'd5) begin
        digits_corr[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign carry_out   = digits_corr[BCD_W-1];
  assign digits_shl  = {digits_corr[BCD_W-2:0], operand_q[IN_WIDTH-1]};
  assign operand_shl = operand_q << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    last_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
          last_shift = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; results only move at the final shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      operand_q    <= '0;
      digits_q     <= '0;
      ovf_sticky_q <= 1'b0;
      sign_q       <= 1'b0;
      cnt_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bcd          <= '0;
      neg          <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        operand_q    <= bin_mag;
        sign_q       <= bin_neg;
        digits_q     <= '0;
        ovf_sticky_q <= 1'b0;
        cnt_q        <= '0;
        busy         <= 1'b1;
      end else if (state_q == SHIFT) begin
        operand_q    <= operand_shl;
        digits_q     <= digits_shl;
        ovf_sticky_q <= ovf_sticky_q | carry_out;
        cnt_q        <= last_shift ? '0 : cnt_q + CNT_W'(1);
        if (last_shift) begin
          bcd  <= digits_shl;
          neg  <= sign_q;
          ovf  <= ovf_sticky_q | carry_out;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: default, SIGNED=1 and DIGITS=2 instances.
module tb_bin_to_bcd_seq;

  typedef struct packed {
    logic [11:0] bcd;
    logic        neg;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;
  logic [7:0]  a_bin = '0, b_bin = '0, c_bin = '0;
  logic        a_busy, a_done, a_neg, a_ovf;
  logic        b_busy, b_done, b_neg, b_ovf;
  logic        c_busy, c_done, c_neg, c_ovf;
  logic [11:0] a_bcd, b_bcd;
  logic [7:0]  c_bcd;

  bin_to_bcd_seq u_a (
    .clk(clk), .rst(rst), .start(a_start), .bin(a_bin),
    .busy(a_busy), .done(a_done), .bcd(a_bcd), .neg(a_neg), .ovf(a_ovf)
  );

  bin_to_bcd_seq #(.SIGNED(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .bin(b_bin),
    .busy(b_busy), .done(b_done), .bcd(b_bcd), .neg(b_neg), .ovf(b_ovf)
  );

  bin_to_bcd_seq #(.DIGITS(2)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .bin(c_bin),
    .busy(c_busy), .done(c_done), .bcd(c_bcd), .neg(c_neg), .ovf(c_ovf)
  );

  res_t q_a[$];
  res_t q_b[$];
  res_t q_c[$];
  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] done_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic res_t get_res(input int sel);
    res_t r;
    case (sel)
      0:       r = '{a_bcd, a_neg, a_ovf};
      1:       r = '{b_bcd, b_neg, b_ovf};
      default: r = '{{4'h0, c_bcd}, c_neg, c_ovf};
    endcase
    return r;
  endfunction

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic push(input int sel, input res_t e);
    case (sel)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic pop(input int sel, output res_t e);
    case (sel)
      0:       e = q_a.pop_front();
      1:       e = q_b.pop_front();
      default: e = q_c.pop_front();
    endcase
  endtask

  task automatic drive(input int sel, input logic s, input logic [7:0] v);
    case (sel)
      0:       begin a_start = s; a_bin = v; end
      1:       begin b_start = s; b_bin = v; end
      default: begin c_start = s; c_bin = v; end
    endcase
  endtask

  // Monitor: every done pulse pops one expected result and compares.
  always @(negedge clk) begin
    res_t e;
    res_t g;
    for (int s = 0; s < 3; s++) begin
      if (!rst && get_done(s)) begin
        check($sformatf("dut%0d_done_width", s), 32'(done_prev[s]), 32'd0);
        if (qsize(s) == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL dut%0d_unexpected_done: got done=1 required no pending result", s);
        end else begin
          pop(s, e);
          g = get_res(s);
          check($sformatf("dut%0d_bcd", s), 32'(g.bcd), 32'(e.bcd));
          check($sformatf("dut%0d_neg", s), 32'(g.neg), 32'(e.neg));
          check($sformatf("dut%0d_ovf", s), 32'(g.ovf), 32'(e.ovf));
        end
      end
      done_prev[s] = get_done(s);
    end
  end

  task automatic wait_done(input int sel, output int nb);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (get_done(sel)) return;
      if (get_busy(sel)) nb++;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL dut%0d_timeout: got no done in 40 cycles required done", sel);
  endtask

  task automatic convert(input int sel, input logic [7:0] v, input res_t e);
    int nb;
    push(sel, e);
    @(posedge clk); #1; drive(sel, 1'b1, v);
    @(posedge clk); #1; drive(sel, 1'b0, v);
    wait_done(sel, nb);
    check($sformatf("dut%0d_busy_cycles", sel), 32'(nb), 32'd8);
  endtask

  initial begin
    int nb;
    int seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_a_done", 32'(a_done), 32'd0);
    check("rst_a_bcd",  32'(a_bcd),  32'd0);
    check("rst_b_neg",  32'(b_neg),  32'd0);
    check("rst_c_ovf",  32'(c_ovf),  32'd0);

    convert(0, 8'd255, '{12'h255, 1'b0, 1'b0});
    convert(0, 8'd0,   '{12'h000, 1'b0, 1'b0});
    convert(0, 8'd99,  '{12'h099, 1'b0, 1'b0});

    convert(1, 8'h80,  '{12'h128, 1'b1, 1'b0});
    convert(1, 8'hF1,  '{12'h015, 1'b1, 1'b0});
    convert(1, 8'h7F,  '{12'h127, 1'b0, 1'b0});

    convert(2, 8'd100, '{12'h000, 1'b0, 1'b1});
    convert(2, 8'd99,  '{12'h099, 1'b0, 1'b0});
    convert(2, 8'd255, '{12'h055, 1'b0, 1'b1});

    // Start during busy is dropped; start in the done cycle is accepted.
    push(0, '{12'h200, 1'b0, 1'b0});
    push(0, '{12'h007, 1'b0, 1'b0});
    @(posedge clk); #1; drive(0, 1'b1, 8'd200);
    @(posedge clk); #1; drive(0, 1'b0, 8'd200);
    @(posedge clk); #1; drive(0, 1'b1, 8'd7);
    @(posedge clk); #1; drive(0, 1'b0, 8'd7);
    wait_done(0, nb);
    drive(0, 1'b1, 8'd7);
    @(posedge clk); #1; drive(0, 1'b0, 8'd7);
    @(negedge clk);
    check("b2b_busy", 32'(a_busy), 32'd1);
    check("b2b_hold_bcd", 32'(a_bcd), 32'h200);
    wait_done(0, nb);
    check("b2b_busy_cycles", 32'(nb), 32'd7);

    // Reset mid-conversion aborts without a done pulse.
    @(posedge clk); #1; drive(0, 1'b1, 8'd255);
    @(posedge clk); #1; drive(0, 1'b0, 8'd255);
    @(posedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_done", 32'(a_done), 32'd0);
    check("abort_bcd",  32'(a_bcd),  32'd0);
    check("abort_neg",  32'(a_neg),  32'd0);
    check("abort_ovf",  32'(a_ovf),  32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (a_done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    convert(0, 8'd99, '{12'h099, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("dut%0d_queue_drained", s), 32'(qsize(s)), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
